// File: rtl/stack_behaviour_param.sv
// Parametrised LIFO stack with wrap/reject overflow policy.
// Registered POP/GET read-out, occupancy flags and an error pulse.
module stack_behaviour_param #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 8,
    parameter int WRAP  = 1,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic             CLK,
    input  logic             RESET_N,
    input  logic [1:0]       COMMAND,
    input  logic [IDX_W-1:0] INDEX,
    input  logic [WIDTH-1:0] D_IN,
    output logic [WIDTH-1:0] D_OUT,
    output logic             OUT_VALID,
    output logic [IDX_W:0]   COUNT,
    output logic             EMPTY,
    output logic             FULL,
    output logic             ERROR
);

    typedef enum logic [1:0] {
        CMD_NOP  = 2'd0,
        CMD_PUSH = 2'd1,
        CMD_POP  = 2'd2,
        CMD_GET  = 2'd3
    } cmd_e;

    localparam logic [IDX_W:0] DEPTH_C = (IDX_W + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [IDX_W-1:0] tp_q, tp_d;
    logic [IDX_W:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic             valid_q, valid_d;
    logic             err_q, err_d;
    logic             empty_q, empty_d;
    logic             full_q, full_d;
    logic             we;
    logic [IDX_W-1:0] top_addr;
    logic [IDX_W-1:0] get_addr;
    cmd_e             cmd;

    assign cmd      = cmd_e'(COMMAND);
    assign top_addr = tp_q - IDX_W'(1);
    assign get_addr = top_addr - INDEX;

    // Decode the command against current occupancy into next state.
    always_comb begin
        tp_d    = tp_q;
        cnt_d   = cnt_q;
        dout_d  = dout_q;
        valid_d = 1'b0;
        err_d   = 1'b0;
        we      = 1'b0;
        unique case (cmd)
            CMD_PUSH: begin
                if (!full_q || (WRAP != 0)) begin
                    we   = 1'b1;
                    tp_d = tp_q + IDX_W'(1);
                    if (!full_q) begin
                        cnt_d = cnt_q + (IDX_W + 1)'(1);
                    end
                end else begin
                    err_d = 1'b1;
                end
            end
            CMD_POP: begin
                if (!empty_q) begin
                    dout_d  = mem_q[top_addr];
                    tp_d    = top_addr;
                    cnt_d   = cnt_q - (IDX_W + 1)'(1);
                    valid_d = 1'b1;
                end else begin
                    dout_d = '0;
                    err_d  = 1'b1;
                end
            end
            CMD_GET: begin
                if ({1'b0, INDEX} < cnt_q) begin
                    dout_d  = mem_q[get_addr];
                    valid_d = 1'b1;
                end else begin
                    dout_d = '0;
                    err_d  = 1'b1;
                end
            end
            default: begin
            end
        endcase
        empty_d = (cnt_d == '0);
        full_d  = (cnt_d == DEPTH_C);
    end

    // Storage array; cleared on reset, written at the top pointer.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we) begin
            mem_q[tp_q] <= D_IN;
        end
    end

    // Pointer, occupancy, flags and registered outputs.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            tp_q    <= '0;
            cnt_q   <= '0;
            dout_q  <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            empty_q <= 1'b1;
            full_q  <= 1'b0;
        end else begin
            tp_q    <= tp_d;
            cnt_q   <= cnt_d;
            dout_q  <= dout_d;
            valid_q <= valid_d;
            err_q   <= err_d;
            empty_q <= empty_d;
            full_q  <= full_d;
        end
    end

    assign D_OUT     = dout_q;
    assign OUT_VALID = valid_q;
    assign COUNT     = cnt_q;
    assign EMPTY     = empty_q;
    assign FULL      = full_q;
    assign ERROR     = err_q;

endmodule

// File: tb/tb_stack_behaviour_param.sv
// Bench for stack_behaviour_param: a wrapping 4x8 and a rejecting 8x16
// instance share one command stream, each checked against a queue model.
module tb_stack_behaviour_param;

    logic       CLK;
    logic       RESET_N;
    logic [1:0] cmd;
    logic [3:0] idx;
    logic [7:0] din;

    logic [3:0] a_dout;
    logic       a_valid, a_empty, a_full, a_err;
    logic [3:0] a_cnt;
    logic [7:0] b_dout;
    logic       b_valid, b_empty, b_full, b_err;
    logic [4:0] b_cnt;

    stack_behaviour_param #(.WIDTH(4), .DEPTH(8), .WRAP(1)) u_a (
        .CLK(CLK), .RESET_N(RESET_N), .COMMAND(cmd), .INDEX(idx[2:0]),
        .D_IN(din[3:0]), .D_OUT(a_dout), .OUT_VALID(a_valid),
        .COUNT(a_cnt), .EMPTY(a_empty), .FULL(a_full), .ERROR(a_err)
    );

    stack_behaviour_param #(.WIDTH(8), .DEPTH(16), .WRAP(0)) u_b (
        .CLK(CLK), .RESET_N(RESET_N), .COMMAND(cmd), .INDEX(idx),
        .D_IN(din), .D_OUT(b_dout), .OUT_VALID(b_valid),
        .COUNT(b_cnt), .EMPTY(b_empty), .FULL(b_full), .ERROR(b_err)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        int dout;
        int valid;
        int err;
        int count;
    } exp_t;

    int tests;
    int failed;
    int depth [2] = '{8, 16};
    int wrapm [2] = '{1, 0};
    int wmask [2] = '{15, 255};
    int imask [2] = '{7, 15};
    int stk0 [$];
    int stk1 [$];
    int dmod [2];
    exp_t sb0 [$];
    exp_t sb1 [$];
    exp_t ea, eb;

    function automatic void chk(string nm, int act, int exp);
        tests++;
        if (act != exp) begin
            failed++;
            $display("FAIL %s: got %0d expected %0d @%0t", nm, act, exp, $time);
        end
    endfunction

    // Reference: stack as a queue, back = top, front = oldest.
    function automatic exp_t model(input int s, input int c,
                                   input int ix, input int d);
        exp_t e;
        int st [$];
        int n;
        st = (s == 0) ? stk0 : stk1;
        ix = ix & imask[s];
        d  = d & wmask[s];
        n  = st.size();
        e.valid = 0;
        e.err   = 0;
        case (c)
            1: begin
                if (n < depth[s]) begin
                    st.push_back(d);
                end else if (wrapm[s] != 0) begin
                    void'(st.pop_front());
                    st.push_back(d);
                end else begin
                    e.err = 1;
                end
            end
            2: begin
                if (n > 0) begin
                    dmod[s] = st.pop_back();
                    e.valid = 1;
                end else begin
                    dmod[s] = 0;
                    e.err   = 1;
                end
            end
            3: begin
                if (ix < n) begin
                    dmod[s] = st[n-1-ix];
                    e.valid = 1;
                end else begin
                    dmod[s] = 0;
                    e.err   = 1;
                end
            end
            default: begin
            end
        endcase
        e.dout  = dmod[s];
        e.count = st.size();
        if (s == 0) stk0 = st;
        else stk1 = st;
        return e;
    endfunction

    task automatic issue(input int c, input int ix, input int d);
        @(negedge CLK);
        cmd = 2'(c);
        idx = 4'(ix);
        din = 8'(d);
        sb0.push_back(model(0, c, ix, d));
        sb1.push_back(model(1, c, ix, d));
    endtask

    task automatic chk_reset_outputs();
        chk("A.rst.dout", int'(a_dout), 0);
        chk("A.rst.count", int'(a_cnt), 0);
        chk("A.rst.empty", int'(a_empty), 1);
        chk("A.rst.full", int'(a_full), 0);
        chk("A.rst.valid", int'(a_valid), 0);
        chk("A.rst.err", int'(a_err), 0);
        chk("B.rst.dout", int'(b_dout), 0);
        chk("B.rst.count", int'(b_cnt), 0);
        chk("B.rst.empty", int'(b_empty), 1);
    endtask

    // Reset between edges while a PUSH is pending; it must be discarded.
    task automatic do_reset();
        @(negedge CLK);
        cmd = 2'd1;
        din = 8'h77;
        #2 RESET_N = 1'b0;
        #1 chk_reset_outputs();
        sb0.delete();
        sb1.delete();
        stk0.delete();
        stk1.delete();
        dmod[0] = 0;
        dmod[1] = 0;
        @(negedge CLK);
        cmd = 2'd0;
        RESET_N = 1'b1;
    endtask

    // Monitor: after each edge, pop the expected response and compare.
    always @(posedge CLK) begin
        #1;
        if (sb0.size() > 0) begin
            ea = sb0.pop_front();
            chk("A.dout", int'(a_dout), ea.dout);
            chk("A.valid", int'(a_valid), ea.valid);
            chk("A.err", int'(a_err), ea.err);
            chk("A.count", int'(a_cnt), ea.count);
            chk("A.empty", int'(a_empty), int'(ea.count == 0));
            chk("A.full", int'(a_full), int'(ea.count == 8));
        end
        if (sb1.size() > 0) begin
            eb = sb1.pop_front();
            chk("B.dout", int'(b_dout), eb.dout);
            chk("B.valid", int'(b_valid), eb.valid);
            chk("B.err", int'(b_err), eb.err);
            chk("B.count", int'(b_cnt), eb.count);
            chk("B.empty", int'(b_empty), int'(eb.count == 0));
            chk("B.full", int'(b_full), int'(eb.count == 16));
        end
    end

    initial begin
        tests   = 0;
        failed  = 0;
        dmod[0] = 0;
        dmod[1] = 0;
        cmd     = 2'd0;
        idx     = 4'd0;
        din     = 8'd0;
        RESET_N = 1'b1;
        #1 RESET_N = 1'b0;
        #2 chk_reset_outputs();
        @(negedge CLK);
        RESET_N = 1'b1;

        // GET on empty stack at every index
        for (int i = 0; i < 16; i++) issue(3, i, 0);

        // push three, read back by depth, one past the top
        for (int i = 1; i <= 3; i++) issue(1, 0, i);
        for (int i = 0; i <= 3; i++) issue(3, i, 0);

        // overfill: A wraps, B keeps everything so far
        do_reset();
        for (int i = 0; i <= 9; i++) issue(1, 0, i);
        for (int i = 0; i < 9; i++) issue(2, 0, 0);

        // B fills to 16, 17th push rejected
        do_reset();
        for (int i = 0; i <= 16; i++) issue(1, 0, i);
        issue(2, 0, 0);
        issue(3, 15, 0);

        // reset between edges after two pushes
        do_reset();
        issue(1, 0, 5);
        issue(1, 0, 6);
        do_reset();
        issue(3, 0, 0);

        // push / get top / pop round trips
        for (int i = 0; i < 100; i++) begin
            issue(1, 0, i % 256);
            issue(3, 0, 0);
            issue(2, 0, 0);
        end

        // random command mix
        for (int i = 0; i < 600; i++) begin
            issue(int'($urandom_range(0, 3)), int'($urandom_range(0, 15)),
                  int'($urandom_range(0, 255)));
        end

        @(negedge CLK);
        cmd = 2'd0;
        repeat (3) @(negedge CLK);
        chk("sb.drained", sb0.size() + sb1.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
